// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: shared types and constants for the delay measurement engine.
// Holds the FSM state encoding, the synchronizer depth and the averaging shift
// used when the design is built with DELAY_METER_AVG_EN.

package delay_meter_pkg;

  // Measurement sequence: wait for a quiet echo, drive the probe, wait for the
  // echo to fall again, or abort through FAULT on a stuck or missing echo.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    RELEASE = 3'd3,
    FAULT   = 3'd4
  } state_e;

  // Number of flops between the asynchronous echo pin and the FSM.
  localparam int SYNC_STAGES = 2;

  // Averaging window is 2**AVG_SHIFT good samples; the mean is acc >> AVG_SHIFT.
  localparam int AVG_SHIFT = 4;

  // Width of the auto-retrigger interval counter. It only ever needs to hold
  // values up to repeat_cycles-1, and it keeps at least one bit when auto mode
  // is disabled so the declaration stays legal.
  function automatic int interval_width(input int unsigned repeat_cycles);
    int w;
    w = 1;
    if (repeat_cycles > 1) begin
      w = $clog2(repeat_cycles);
    end
    return w;
  endfunction

endpackage

// File: rtl/delay_meter_if.sv
// delay_meter_if: probe/echo pins plus the result handshake presented to the
// display/formatting stage. The measurement engine connects through the slave
// modport; whoever drives start and the echo pin uses the master modport.

interface delay_meter_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             echo_in;
  logic             probe_out;
  logic [CNT_W-1:0] delay;
  logic             valid;
  logic             timeout;
  logic             busy;

  modport master (
    output start,
    output echo_in,
    input  probe_out,
    input  delay,
    input  valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  start,
    input  echo_in,
    output probe_out,
    output delay,
    output valid,
    output timeout,
    output busy
  );

endinterface

// File: rtl/delay_meter_sync2.sv
// sync2: multi-flop synchronizer (SYNC_STAGES deep) for asynchronous pins such
// as the echo input or front-panel buttons. Synchronous active-high reset
// clears every stage so the output reads 0 right after reset.

module sync2
  import delay_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw pin value one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  // Synchronizer flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/delay_meter.sv
// delay_meter: counts clk16M cycles from probe rising to synchronized echo
// rising and reports the result with a one-cycle valid strobe. Measurements
// start on a start pulse in IDLE or automatically every REPEAT IDLE cycles.
// Results include the synchronizer latency (a wire loopback reads 2).
// Optional build macro DELAY_METER_AVG_EN: report the mean of 16 good samples
// instead of every sample; faults still report immediately.

module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF,
  parameter int unsigned REPEAT  = 1600000
)(
  input  logic          clk16M,
  input  logic          rstbt,
  delay_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam int               INT_W       = interval_width(REPEAT);
  localparam logic [INT_W-1:0] REPEAT_LAST = INT_W'(REPEAT - 1);
  localparam bit               AUTO_EN     = (REPEAT != 0);

  // Synchronized echo pin.
  logic echo_s;

  // FSM state and counters.
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [INT_W-1:0] int_cnt_q, int_cnt_d;

  // Registered outputs.
  logic             probe_q,   probe_d;
  logic [CNT_W-1:0] delay_q,   delay_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q,    busy_d;

  // Decoded events.
  logic             auto_fire;
  logic             trigger;
  logic             sample_ok;

`ifdef DELAY_METER_AVG_EN
  // Running sum of good samples and how many have been collected so far.
  logic [CNT_W+AVG_SHIFT-1:0] acc_q,  acc_d;
  logic [CNT_W+AVG_SHIFT-1:0] acc_sum;
  logic [AVG_SHIFT-1:0]       samp_q, samp_d;
`endif

  sync2 u_echo_sync (
    .clk   (clk16M),
    .rst   (rstbt),
    .d_in  (bus.echo_in),
    .q_out (echo_s)
  );

  // Trigger decode: a start pulse or the interval counter expiring; both in the
  // same cycle still give a single measurement since IDLE is left only once.
  always_comb begin
    auto_fire = 1'b0;
    if (AUTO_EN && (int_cnt_q == REPEAT_LAST)) begin
      auto_fire = 1'b1;
    end
    trigger = bus.start || auto_fire;
  end

  // Next-state and result logic; every output is computed from the next state
  // so the flops present it in the same cycle the FSM is in that state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    int_cnt_d = int_cnt_q;
    delay_d   = delay_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    sample_ok = 1'b0;
`ifdef DELAY_METER_AVG_EN
    acc_d     = acc_q;
    samp_d    = samp_q;
    acc_sum   = acc_q + {{AVG_SHIFT{1'b0}}, cnt_q};
`endif

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = ARM;
          cnt_d     = '0;
          int_cnt_d = '0;
        end else if (AUTO_EN) begin
          int_cnt_d = int_cnt_q + 1'b1;
        end
      end

      ARM: begin
        if (!echo_s) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MEASURE: begin
        if (echo_s) begin
          state_d   = RELEASE;
          cnt_d     = '0;
          sample_ok = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!echo_s) begin
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FAULT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == FAULT) begin
      delay_d   = '1;
      timeout_d = 1'b1;
      valid_d   = 1'b1;
`ifdef DELAY_METER_AVG_EN
      acc_d     = '0;
      samp_d    = '0;
`endif
    end else if (sample_ok) begin
`ifdef DELAY_METER_AVG_EN
      if (samp_q == '1) begin
        delay_d   = acc_sum[CNT_W+AVG_SHIFT-1:AVG_SHIFT];
        timeout_d = 1'b0;
        valid_d   = 1'b1;
        acc_d     = '0;
        samp_d    = '0;
      end else begin
        acc_d  = acc_sum;
        samp_d = samp_q + 1'b1;
      end
`else
      delay_d   = cnt_q;
      timeout_d = 1'b0;
      valid_d   = 1'b1;
`endif
    end

    probe_d = (state_d == MEASURE);
    busy_d  = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset aborts any measurement.
  always_ff @(posedge clk16M) begin
    if (rstbt) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      int_cnt_q <= '0;
      probe_q   <= 1'b0;
      delay_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      int_cnt_q <= int_cnt_d;
      probe_q   <= probe_d;
      delay_q   <= delay_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

`ifdef DELAY_METER_AVG_EN
  // Averaging accumulator, emptied on reset, on report and on any fault.
  always_ff @(posedge clk16M) begin
    if (rstbt) begin
      acc_q  <= '0;
      samp_q <= '0;
    end else begin
      acc_q  <= acc_d;
      samp_q <= samp_d;
    end
  end
`endif

  assign bus.probe_out = probe_q;
  assign bus.delay     = delay_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: directed and randomized checks of delay_meter. DUT A runs
// manual triggering with a short timeout and an echo path that can be a
// delayed copy of the probe or tied low/high; DUT B runs auto-retrigger with a
// wire loopback. Expected delays come from the external delay plus the
// synchronizer depth; faults expect all ones with the timeout flag set.

module tb_delay_meter;
  import delay_meter_pkg::*;

  localparam int CNT_W     = 16;
  localparam int TIMEOUT_A = 100;
  localparam int REPEAT_B  = 50;
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  logic clk16M = 1'b0;
  logic rstbt;

  int checks   = 0;
  int failures = 0;

  int          echoMode  = 1;
  int          echoDelay = 0;
  logic [63:0] probeHist = '0;

  delay_meter_if #(.CNT_W(CNT_W)) busA ();
  delay_meter_if #(.CNT_W(CNT_W)) busB ();

  delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT_A), .REPEAT(0)) dutA (
    .clk16M (clk16M),
    .rstbt  (rstbt),
    .bus    (busA)
  );

  delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT_A), .REPEAT(REPEAT_B)) dutB (
    .clk16M (clk16M),
    .rstbt  (rstbt),
    .bus    (busB)
  );

  always #5 clk16M = ~clk16M;

  // Probe history so the echo can be the probe delayed by a whole number of cycles.
  always @(posedge clk16M) begin
    probeHist <= {probeHist[62:0], busA.probe_out};
  end

  // Echo source for DUT A: delayed loopback, tied low or tied high.
  always_comb begin
    case (echoMode)
      1:       busA.echo_in = 1'b0;
      2:       busA.echo_in = 1'b1;
      default: busA.echo_in = (echoDelay == 0) ? busA.probe_out
                                               : probeHist[(echoDelay == 0) ? 0 : echoDelay - 1];
    endcase
  end

  assign busB.echo_in = busB.probe_out;
  assign busB.start   = 1'b0;

  // Reference model: cycles of external delay plus synchronizer latency.
  function automatic int expectedDelay(input int extDelay);
    return extDelay + SYNC_STAGES;
  endfunction

  // Reference model for averaging: truncated mean of the collected samples.
  function automatic int expectedMean(input int samples[$]);
    int sum;
    sum = 0;
    foreach (samples[i]) sum += samples[i];
    return sum / samples.size();
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setEcho(input int mode, input int dly, input int settle);
    echoMode  = mode;
    echoDelay = dly;
    for (int i = 0; i < settle; i++) @(negedge clk16M);
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic applyStimulus();
    @(negedge clk16M);
    busA.start = 1'b1;
    @(negedge clk16M);
    busA.start = 1'b0;
  endtask

  task automatic waitValid(input int budget, output bit seen,
                           output logic [CNT_W-1:0] d, output logic t);
    seen = 1'b0;
    d    = '0;
    t    = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk16M);
      if (busA.valid) begin
        seen = 1'b1;
        d    = busA.delay;
        t    = busA.timeout;
      end
    end
  endtask

  task automatic waitIdle(input int budget, output bit idle, output int nValid,
                          output logic [CNT_W-1:0] lastDelay);
    idle      = 1'b0;
    nValid    = 0;
    lastDelay = '0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk16M);
      if (busA.valid) begin
        nValid++;
        lastDelay = busA.delay;
      end
      if (!busA.busy) idle = 1'b1;
    end
  endtask

  task automatic measureOnce(input string tag, input int dly);
    bit               seen;
    bit               idle;
    int               nv;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] ld;
    logic             t;
    setEcho(0, dly, dly + 6);
    applyStimulus();
    waitValid(dly + 40, seen, d, t);
    checkOutput({tag, "_valid_seen"}, seen, 1);
    checkOutput({tag, "_delay"}, d, expectedDelay(dly));
    checkOutput({tag, "_timeout"}, t, 0);
    waitIdle(dly + 40, idle, nv, ld);
    checkOutput({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    bit               seen;
    bit               idle;
    bit               ok;
    int               nv;
    int               dly;
    int               lowCnt;
    int               samples[$];
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] ld;
    logic             t;

    busA.start = 1'b0;
    rstbt      = 1'b1;
    setEcho(1, 0, 4);
    checkOutput("reset_probe",   busA.probe_out, 0);
    checkOutput("reset_delay",   busA.delay,     0);
    checkOutput("reset_valid",   busA.valid,     0);
    checkOutput("reset_timeout", busA.timeout,   0);
    checkOutput("reset_busy",    busA.busy,      0);
    rstbt = 1'b0;

`ifndef DELAY_METER_AVG_EN
    $display("[TB] wire loopback latency");
    setEcho(0, 0, 4);
    applyStimulus();
    checkOutput("wire_busy_after_start",  busA.busy,      1);
    checkOutput("wire_probe_first_cycle", busA.probe_out, 0);
    @(negedge clk16M);
    checkOutput("wire_probe_rises", busA.probe_out, 1);
    waitValid(40, seen, d, t);
    checkOutput("wire_valid_seen", seen, 1);
    checkOutput("wire_delay",      d,    expectedDelay(0));
    checkOutput("wire_timeout",    t,    0);
    @(negedge clk16M);
    checkOutput("wire_valid_one_cycle", busA.valid, 0);
    waitIdle(40, idle, nv, ld);
    checkOutput("wire_idle", idle, 1);

    measureOnce("ext5", 5);

    $display("[TB] randomized external delays");
    for (int k = 0; k < 6; k++) begin
      dly = $urandom_range(0, 20);
      measureOnce($sformatf("rand%0d_d%0d", k, dly), dly);
    end
`endif

    $display("[TB] echo stuck low");
    setEcho(1, 0, 4);
    applyStimulus();
    waitValid(TIMEOUT_A + 40, seen, d, t);
    checkOutput("low_valid_seen", seen, 1);
    checkOutput("low_delay",      d,    ALL_ONES);
    checkOutput("low_timeout",    t,    1);
    @(negedge clk16M);
    checkOutput("low_probe_after", busA.probe_out, 0);
    checkOutput("low_valid_after", busA.valid,     0);

    $display("[TB] echo stuck high before start");
    setEcho(2, 0, 4);
    applyStimulus();
    waitValid(TIMEOUT_A + 40, seen, d, t);
    checkOutput("high_valid_seen", seen,           1);
    checkOutput("high_delay",      d,              ALL_ONES);
    checkOutput("high_timeout",    t,              1);
    checkOutput("high_probe",      busA.probe_out, 0);

`ifndef DELAY_METER_AVG_EN
    measureOnce("recover", 0);

    $display("[TB] echo stuck high in release");
    setEcho(0, 0, 4);
    applyStimulus();
    waitValid(40, seen, d, t);
    checkOutput("rel_first_delay", d, expectedDelay(0));
    echoMode = 2;
    waitValid(TIMEOUT_A + 40, seen, d, t);
    checkOutput("rel_fault_seen",    seen, 1);
    checkOutput("rel_fault_delay",   d,    ALL_ONES);
    checkOutput("rel_fault_timeout", t,    1);

    $display("[TB] start while busy is ignored");
    setEcho(0, 10, 20);
    applyStimulus();
    @(negedge clk16M);
    @(negedge clk16M);
    busA.start = 1'b1;
    @(negedge clk16M);
    busA.start = 1'b0;
    waitIdle(80, idle, nv, ld);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk16M);
      if (busA.valid || busA.busy) nv += 100;
    end
    checkOutput("busy_start_valids", nv, 1);
    checkOutput("busy_start_delay",  ld, expectedDelay(10));
`else
    $display("[TB] averaging over 16 samples");
    samples.delete();
    nv = 0;
    ld = '0;
    for (int k = 0; k < 16; k++) begin
      int n;
      dly = (k % 2 == 0) ? 0 : 8;
      samples.push_back(expectedDelay(dly));
      setEcho(0, dly, 14);
      applyStimulus();
      waitIdle(80, idle, n, d);
      if (n != 0) ld = d;
      nv += n;
    end
    checkOutput("avg_valid_count", nv, 1);
    checkOutput("avg_delay",       ld, expectedMean(samples));
    checkOutput("avg_timeout",     busA.timeout, 0);
`endif

    $display("[TB] reset during measure");
    setEcho(1, 0, 4);
    applyStimulus();
    for (int i = 0; i < 10; i++) @(negedge clk16M);
    checkOutput("rst_in_measure_probe", busA.probe_out, 1);
    rstbt = 1'b1;
    @(negedge clk16M);
    rstbt = 1'b0;
    checkOutput("rst_probe",   busA.probe_out, 0);
    checkOutput("rst_delay",   busA.delay,     0);
    checkOutput("rst_valid",   busA.valid,     0);
    checkOutput("rst_timeout", busA.timeout,   0);
    checkOutput("rst_busy",    busA.busy,      0);
    nv = 0;
    for (int i = 0; i < TIMEOUT_A + 30; i++) begin
      @(negedge clk16M);
      if (busA.valid) nv++;
    end
    checkOutput("rst_no_valid", nv, 0);

    $display("[TB] auto retrigger");
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk16M);
      if (busB.busy) ok = 1'b1;
    end
    checkOutput("auto_first_trigger", ok, 1);
    ok = 1'b0;
    nv = 0;
    d  = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk16M);
      if (busB.valid) begin
        nv++;
        d = busB.delay;
      end
      if (!busB.busy) ok = 1'b1;
    end
    checkOutput("auto_meas_done", ok, 1);
`ifndef DELAY_METER_AVG_EN
    checkOutput("auto_valid_count", nv, 1);
    checkOutput("auto_delay",       d,  expectedDelay(0));
`endif
    lowCnt = 1;
    ok     = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk16M);
      if (busB.busy) ok = 1'b1;
      else lowCnt++;
    end
    checkOutput("auto_retrigger", ok,     1);
    checkOutput("auto_interval",  lowCnt, REPEAT_B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
